// File: rtl/ap_out_collector_if.sv
// Write-side bus of the accelerator output collector: show-ahead word, byte mask and
// word address, with a valid/ready handshake towards the result memory.
interface ap_out_collector_if #(
    parameter int outport = 8,
    parameter int N_core  = 8,
    parameter int AW      = 10
);
    logic                      wr_valid;
    logic                      wr_ready;
    logic [outport*N_core-1:0] wr_data;
    logic [N_core-1:0]         wr_mask;
    logic [AW-1:0]             wr_addr;

    modport master (output wr_valid, output wr_data, output wr_mask, output wr_addr, input wr_ready);
    modport slave  (input wr_valid, input wr_data, input wr_mask, input wr_addr, output wr_ready);
endinterface

// File: rtl/ap_out_collector.sv
// Collects per-core accelerator results into a small show-ahead FIFO and streams them
// to memory as masked words at consecutive addresses, one frame per start pulse.
module ap_out_collector #(
    parameter int outport = 8,
    parameter int N_core  = 8,
    parameter int DEPTH   = 4,
    parameter int AW      = 10
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [outport*N_core-1:0] in_data,
    input  logic [N_core-1:0]         in_en,
    input  logic                      start,
    input  logic [AW-1:0]             frame_len,
    ap_out_collector_if.master        wr,
    output logic                      busy,
    output logic                      done,
    output logic                      overflow,
    output logic [$clog2(DEPTH):0]    fifo_level
);
    localparam int DW = outport * N_core;
    localparam int EW = DW + N_core;
    localparam int PW = $clog2(DEPTH);
    localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [PW:0]   CNT_ONE  = {{PW{1'b0}}, 1'b1};
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [EW-1:0] mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW:0]   count_r;
    logic [AW-1:0] addr_r;
    logic [AW-1:0] push_cnt_r;
    logic [AW-1:0] push_cnt_inc_s;
    logic [AW-1:0] frame_len_r;
    logic          done_r;
    logic          done_nxt_s;
    logic          overflow_r;
    logic [DW-1:0] lane_data_s;
    logic [EW-1:0] head_s;
    logic          empty_s;
    logic          full_s;
    logic          push_s;
    logic          pop_s;
    logic          accept_s;
    logic          drop_s;
    logic          frame_start_s;

    assign empty_s        = (count_r == '0);
    assign full_s         = (count_r == CNT_FULL);
    assign push_s         = (state_r == ST_RUN) && (in_en != '0);
    assign pop_s          = !empty_s && wr.wr_ready;
    // A full FIFO still takes the new entry when the head leaves in the same cycle.
    assign accept_s       = push_s && (!full_s || pop_s);
    assign drop_s         = push_s && full_s && !pop_s;
    assign frame_start_s  = (state_r == ST_IDLE) && start && (frame_len != '0);
    assign push_cnt_inc_s = push_cnt_r + ADDR_ONE;
    assign head_s         = mem_r[rd_ptr_r];

    assign wr.wr_valid = !empty_s;
    assign wr.wr_data  = empty_s ? '0 : head_s[EW-1:N_core];
    assign wr.wr_mask  = empty_s ? '0 : head_s[N_core-1:0];
    assign wr.wr_addr  = addr_r;
    assign busy        = (state_r != ST_IDLE);
    assign done        = done_r;
    assign overflow    = overflow_r;
    assign fifo_level  = count_r;

    // Zero the lanes whose enable bit is clear.
    always_comb begin
        lane_data_s = '0;
        for (int k = 0; k < N_core; k++) begin
            if (in_en[k]) begin
                lane_data_s[outport*k +: outport] = in_data[outport*k +: outport];
            end else begin
                lane_data_s[outport*k +: outport] = '0;
            end
        end
    end

    // Next-state and done-pulse decode.
    always_comb begin
        state_nxt_s = state_r;
        done_nxt_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start && (frame_len == '0)) begin
                    done_nxt_s = 1'b1;
                end else if (start) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (push_s && (push_cnt_inc_s == frame_len_r)) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (empty_s) begin
                    state_nxt_s = ST_IDLE;
                    done_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                done_nxt_s  = 1'b0;
            end
        endcase
    end

    // State register and done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    // FIFO storage; only slots between the pointers are ever observed.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            mem_r[wr_ptr_r] <= {lane_data_s, in_en};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (accept_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({accept_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Frame bookkeeping: length, push attempts, write address and sticky overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_len_r <= '0;
            push_cnt_r  <= '0;
            addr_r      <= '0;
            overflow_r  <= 1'b0;
        end else if (frame_start_s) begin
            frame_len_r <= frame_len;
            push_cnt_r  <= '0;
            addr_r      <= '0;
            overflow_r  <= 1'b0;
        end else begin
            if (push_s) begin
                push_cnt_r <= push_cnt_inc_s;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
            if (pop_s) begin
                addr_r <= addr_r + ADDR_ONE;
            end
        end
    end
endmodule

// File: tb/tb_ap_out_collector.sv
// Randomized and directed bench for ap_out_collector, checked cycle by cycle against a
// queue-based reference model of the frame/FIFO rules.
module tb_ap_out_collector;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  m;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] in_data;
    logic [7:0]  in_en;
    logic        start;
    logic [9:0]  frame_len;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [2:0]  fifo_level;

    ap_out_collector_if #(.outport(8), .N_core(8), .AW(10)) bus ();

    ap_out_collector #(.outport(8), .N_core(8), .DEPTH(DEPTH), .AW(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_en      (in_en),
        .start      (start),
        .frame_len  (frame_len),
        .wr         (bus),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    int n_total  = 0;
    int n_bad    = 0;
    int wr_obs   = 0;
    int done_obs = 0;

    // Reference model: 0 = idle, 1 = collecting, 2 = draining.
    int          m_mode;
    int          m_left;
    logic [9:0]  m_addr;
    logic        m_ovf;
    logic        exp_done;
    ent_t        q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_mode   = 0;
        m_left   = 0;
        m_addr   = 10'd0;
        m_ovf    = 1'b0;
        exp_done = 1'b0;
    endtask

    task automatic model_edge(input logic st, input logic [9:0] fl, input logic [7:0] en,
                              input logic [63:0] dat, input logic rdy);
        int          pre_mode;
        int          pre_size;
        bit          pop;
        ent_t        e;
        logic [63:0] bm;
        pre_mode = m_mode;
        pre_size = q.size();
        pop      = (pre_size != 0) && rdy;
        exp_done = 1'b0;
        if (pop) begin
            void'(q.pop_front());
            m_addr = m_addr + 10'd1;
        end
        if (pre_mode == 0 && st) begin
            if (fl == 10'd0) begin
                exp_done = 1'b1;
            end else begin
                m_mode = 1;
                m_left = int'(fl);
                m_addr = 10'd0;
                m_ovf  = 1'b0;
            end
        end else if (pre_mode == 1 && en != 8'h00) begin
            for (int k = 0; k < 8; k++) bm[8*k +: 8] = {8{en[k]}};
            e.d = dat & bm;
            e.m = en;
            if (pre_size < DEPTH || pop) q.push_back(e);
            else m_ovf = 1'b1;
            m_left--;
            if (m_left == 0) m_mode = 2;
        end else if (pre_mode == 2 && pre_size == 0) begin
            m_mode   = 0;
            exp_done = 1'b1;
        end
    endtask

    task automatic check_outputs();
        chk("valid", 64'(bus.wr_valid), 64'(q.size() != 0));
        chk("level", 64'(fifo_level), 64'(q.size()));
        if (q.size() != 0) begin
            chk("data", bus.wr_data, q[0].d);
            chk("mask", 64'(bus.wr_mask), 64'(q[0].m));
        end
        chk("addr", 64'(bus.wr_addr), 64'(m_addr));
        chk("busy", 64'(busy), 64'(m_mode != 0));
        chk("done", 64'(done), 64'(exp_done));
        chk("overflow", 64'(overflow), 64'(m_ovf));
    endtask

    task automatic step(input logic st, input logic [9:0] fl, input logic [7:0] en,
                        input logic [63:0] dat, input logic rdy);
        start        = st;
        frame_len    = fl;
        in_en        = en;
        in_data      = dat;
        bus.wr_ready = rdy;
        if (bus.wr_valid && rdy) wr_obs++;
        model_edge(st, fl, en, dat, rdy);
        @(posedge clk);
        #1;
        if (done) done_obs++;
        check_outputs();
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 10'd0, 8'h00, 64'd0, rdy);
    endtask

    task automatic apply_reset();
        start        = 1'b0;
        frame_len    = 10'd0;
        in_en        = 8'h00;
        in_data      = 64'd0;
        bus.wr_ready = 1'b0;
        reset        = 1'b0;
        #1;
        model_clear();
        chk("rst_valid", 64'(bus.wr_valid), 64'd0);
        chk("rst_level", 64'(fifo_level), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_addr", 64'(bus.wr_addr), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        int base_w;
        int base_d;
        reset = 1'b1;
        #2;
        apply_reset();

        // Three full-mask pushes, memory always ready.
        base_w = wr_obs;
        base_d = done_obs;
        step(1'b1, 10'd3, 8'h00, 64'd0, 1'b1);
        step(1'b0, 10'd0, 8'hFF, 64'h0102_0304_0506_0708, 1'b1);
        chk("r039_data0", bus.wr_data, 64'h0102_0304_0506_0708);
        chk("r039_addr0", 64'(bus.wr_addr), 64'd0);
        step(1'b0, 10'd0, 8'hFF, 64'h1112_1314_1516_1718, 1'b1);
        step(1'b0, 10'd0, 8'hFF, 64'h2122_2324_2526_2728, 1'b1);
        idle(6, 1'b1);
        chk("r039_writes", 64'(wr_obs - base_w), 64'd3);
        chk("r039_done", 64'(done_obs - base_d), 64'd1);
        chk("r039_busy", 64'(busy), 64'd0);

        // Lane masking.
        step(1'b1, 10'd1, 8'h00, 64'd0, 1'b0);
        step(1'b0, 10'd0, 8'h05, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        chk("r040_data", bus.wr_data, 64'h0000_0000_00FF_00FF);
        chk("r040_mask", 64'(bus.wr_mask), 64'h05);
        idle(4, 1'b1);

        // Overflow with memory stalled, then drain.
        step(1'b1, 10'd6, 8'h00, 64'd0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 10'd0, 8'hFF, {$urandom, $urandom}, 1'b0);
        chk("r041_level", 64'(fifo_level), 64'd4);
        chk("r041_overflow", 64'(overflow), 64'd1);
        base_w = wr_obs;
        base_d = done_obs;
        idle(8, 1'b1);
        chk("r041_writes", 64'(wr_obs - base_w), 64'd4);
        chk("r041_done", 64'(done_obs - base_d), 64'd1);
        chk("r041_addr", 64'(bus.wr_addr), 64'd4);

        // Push and pop together on a full FIFO.
        step(1'b1, 10'd8, 8'h00, 64'd0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 10'd0, 8'h3C, {$urandom, $urandom}, 1'b0);
        step(1'b0, 10'd0, 8'hC3, {$urandom, $urandom}, 1'b1);
        chk("r042_level", 64'(fifo_level), 64'd4);
        chk("r042_overflow", 64'(overflow), 64'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 10'd0, 8'h81, {$urandom, $urandom}, 1'b1);
        idle(8, 1'b1);

        // Zero-length frame, then a start ignored mid-frame.
        step(1'b1, 10'd0, 8'hFF, 64'd1, 1'b1);
        chk("r043_valid", 64'(bus.wr_valid), 64'd0);
        chk("r043_done", 64'(done), 64'd1);
        step(1'b1, 10'd4, 8'h00, 64'd0, 1'b1);
        step(1'b0, 10'd0, 8'h0F, {$urandom, $urandom}, 1'b1);
        step(1'b0, 10'd0, 8'hF0, {$urandom, $urandom}, 1'b1);
        step(1'b1, 10'd7, 8'h11, {$urandom, $urandom}, 1'b1);
        step(1'b0, 10'd0, 8'h22, {$urandom, $urandom}, 1'b1);
        idle(6, 1'b1);
        chk("r043_addr", 64'(bus.wr_addr), 64'd4);
        chk("r043_busy", 64'(busy), 64'd0);

        // Reset with entries queued.
        step(1'b1, 10'd5, 8'h00, 64'd0, 1'b0);
        step(1'b0, 10'd0, 8'hFF, {$urandom, $urandom}, 1'b0);
        step(1'b0, 10'd0, 8'hFF, {$urandom, $urandom}, 1'b0);
        chk("r044_level_before", 64'(fifo_level), 64'd2);
        apply_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 10'd0, 8'hFF, {$urandom, $urandom}, 1'b1);

        // Random traffic.
        for (int i = 0; i < 2500; i++) begin
            logic        r_st;
            logic [9:0]  r_fl;
            logic [7:0]  r_en;
            logic        r_rdy;
            r_st  = ($urandom_range(0, 7) == 0);
            r_fl  = 10'($urandom_range(0, 9));
            r_en  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            r_rdy = ($urandom_range(0, 2) != 0);
            step(r_st, r_fl, r_en, {$urandom, $urandom}, r_rdy);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
